// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared FUNC3 codes, FSM states and the latched request record.
package data_memory_responder_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
    } req_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: CPU data-memory bus between the pipeline (master) and the memory (slave).
interface data_memory_responder_if;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [2:0]  FUNC3;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, FUNC3,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, FUNC3,
        output READDATA, BUSYWAIT
    );
endinterface

// File: rtl/data_memory_responder_mem_lane_align.sv
// mem_lane_align: byte enables and lane replication for stores, lane extraction and extension for loads.
module mem_lane_align
    import data_memory_responder_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        byte_en = func3 == F3_B ? 4'b0001 << lane
                : func3 == F3_H ? (lane[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
        wword   = func3 == F3_B ? {4{wdata[7:0]}}
                : func3 == F3_H ? {2{wdata[15:0]}}
                : wdata;
        rbyte   = rword[8*lane +: 8];
        rhalf   = lane[1] ? rword[31:16] : rword[15:0];
        rdata   = func3 == F3_B  ? {{24{rbyte[7]}}, rbyte}
                : func3 == F3_BU ? {24'b0, rbyte}
                : func3 == F3_H  ? {{16{rhalf[15]}}, rhalf}
                : func3 == F3_HU ? {16'b0, rhalf}
                : rword;
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-array data memory that stalls the CPU via BUSYWAIT for LATENCY cycles per access.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input logic CLK,
    input logic RESET,
    data_memory_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_t        state;
    logic [CW-1:0] count;
    req_t          req_q;
    req_t          req;
    logic          start;
    logic          commit;
    logic [AW-1:0] idx;
    logic [3:0]    byte_en;
    logic [31:0]   wword;
    logic [31:0]   rdata;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          unused_addr;

    // In IDLE the live request drives the datapath so LATENCY=1 can commit at the latching edge.
    always_comb begin
        start  = RESET && state == IDLE && (bus.READ || bus.WRITE);
        req    = state == IDLE ? req_t'{write: bus.WRITE, addr: bus.ADDRESS,
                                        wdata: bus.WRITEDATA, func3: bus.FUNC3}
                               : req_q;
        commit = RESET && ((start && LATENCY == 1) || (state == ACCESS && count == '0));
        idx    = req.addr[AW+1:2];
    end

    assign bus.BUSYWAIT = start || state == ACCESS;
    assign unused_addr  = ^req.addr[31:AW+2];

    mem_lane_align u_align (
        .func3  (req.func3),
        .lane   (req.addr[1:0]),
        .wdata  (req.wdata),
        .rword  (mem[idx]),
        .byte_en(byte_en),
        .wword  (wword),
        .rdata  (rdata)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            count        <= '0;
            req_q        <= '0;
            bus.READDATA <= '0;
        end else begin
            if (commit && !req.write) bus.READDATA <= rdata;
            case (state)
                IDLE: if (start) begin
                    req_q <= req;
                    if (LATENCY == 1) state <= DONE;
                    else begin
                        count <= CW'(LATENCY - 2);
                        state <= ACCESS;
                    end
                end
                ACCESS: if (count == '0) state <= DONE;
                        else count <= count - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // The array is deliberately outside the reset domain; commit already excludes reset.
    always_ff @(posedge CLK) begin
        if (commit && req.write)
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for a LATENCY=4 and a LATENCY=1 responder.
module tb_data_memory_responder;
    logic        CLK = 0;
    logic        RESET = 1;
    logic        rd = 0, wr = 0, sel = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [2:0]  f3 = 0;
    int          vectors = 0, errors = 0;
    logic [31:0] sb[$];

    data_memory_responder_if bus4();
    data_memory_responder_if bus1();

    assign bus4.READ = rd & ~sel;
    assign bus4.WRITE = wr & ~sel;
    assign bus4.ADDRESS = addr;
    assign bus4.WRITEDATA = wdata;
    assign bus4.FUNC3 = f3;
    assign bus1.READ = rd & sel;
    assign bus1.WRITE = wr & sel;
    assign bus1.ADDRESS = addr;
    assign bus1.WRITEDATA = wdata;
    assign bus1.FUNC3 = f3;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus4.slave));
    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1.slave));

    always #5 CLK = ~CLK;

    // Drives one request at a negedge, counts busy samples, returns READDATA seen in DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, output int busy, output logic [31:0] got);
        @(negedge CLK);
        rd = r; wr = w; addr = a; wdata = d; f3 = f;
        #1;
        busy = 0;
        while ((sel ? bus1.BUSYWAIT : bus4.BUSYWAIT) && busy < 40) begin
            busy++;
            @(negedge CLK);
            #1;
        end
        got = sel ? bus1.READDATA : bus4.READDATA;
        rd = 0; wr = 0;
    endtask

    task automatic test_reset;
        RESET = 0;
        repeat (2) @(negedge CLK);
        #1;
        vectors += 4;
        if (bus4.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b want=0", bus4.BUSYWAIT); end
        if (bus4.READDATA !== 32'h0) begin errors++; $display("FAIL reset_rd4 got=%h want=0", bus4.READDATA); end
        if (bus1.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b want=0", bus1.BUSYWAIT); end
        if (bus1.READDATA !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h want=0", bus1.READDATA); end
        RESET = 1;
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if (bus4.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", bus4.BUSYWAIT); end
    endtask

    task automatic test_store_load;
        int b;
        logic [31:0] g;
        access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, b, g);
        vectors++;
        if (b != 4) begin errors++; $display("FAIL sw_busy got=%0d want=4", b); end
        sb.push_back(32'hDEADBEEF);
        access(1, 0, 32'h10, 32'h0, 3'b010, b, g);
        vectors += 2;
        if (b != 4) begin errors++; $display("FAIL lw_busy got=%0d want=4", b); end
        if (g !== sb.pop_front()) begin errors++; $display("FAIL lw_data got=%h want=deadbeef", g); end
    endtask

    task automatic test_extension;
        int b;
        logic [31:0] g, e;
        logic [31:0] ad[8] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10, 32'h11, 32'h12};
        logic [2:0]  fs[8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100, 3'b000};
        logic [31:0] ex[8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01,
                               32'h00000001, 32'h00007F01, 32'h0000007F, 32'hFFFFFFF1};
        access(0, 1, 32'h10, 32'h80F17F01, 3'b010, b, g);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ex[i]);
            access(1, 0, ad[i], 32'h0, fs[i], b, g);
            e = sb.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL ext_%0d got=%h want=%h", i, g, e); end
        end
    endtask

    task automatic test_partial_stores;
        int b;
        logic [31:0] g, e;
        access(0, 1, 32'h20, 32'h11223344, 3'b010, b, g);
        access(0, 1, 32'h21, 32'hFFFFFFAA, 3'b000, b, g);
        vectors++;
        if (b != 4) begin errors++; $display("FAIL sb_busy got=%0d want=4", b); end
        sb.push_back(32'h1122AA44);
        access(1, 0, 32'h20, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors++;
        if (g !== e) begin errors++; $display("FAIL sb_data got=%h want=%h", g, e); end
        access(0, 1, 32'h22, 32'h1234BEEF, 3'b001, b, g);
        vectors++;
        if (g !== 32'h1122AA44) begin errors++; $display("FAIL rd_hold got=%h want=1122aa44", g); end
        sb.push_back(32'hBEEFAA44);
        access(1, 0, 32'h20, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors++;
        if (g !== e) begin errors++; $display("FAIL sh_data got=%h want=%h", g, e); end
        access(1, 1, 32'h24, 32'h00000055, 3'b010, b, g);
        vectors++;
        if (g !== 32'hBEEFAA44) begin errors++; $display("FAIL rw_hold got=%h want=beefaa44", g); end
        sb.push_back(32'h00000055);
        access(1, 0, 32'h24, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors++;
        if (g !== e) begin errors++; $display("FAIL rw_write got=%h want=%h", g, e); end
    endtask

    task automatic test_wrap;
        int b;
        logic [31:0] g, e;
        access(0, 1, 32'h400, 32'h5, 3'b010, b, g);
        sb.push_back(32'h5);
        access(1, 0, 32'h000, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors++;
        if (g !== e) begin errors++; $display("FAIL wrap got=%h want=%h", g, e); end
    endtask

    task automatic test_back_to_back;
        int b;
        logic [31:0] g, e;
        access(0, 1, 32'h40, 32'h0BADCAFE, 3'b010, b, g);
        access(0, 1, 32'h44, 32'h13579BDF, 3'b010, b, g);
        sb.push_back(32'h0BADCAFE);
        sb.push_back(32'h13579BDF);
        @(negedge CLK);
        rd = 1; addr = 32'h40; f3 = 3'b010;
        #1;
        b = 0;
        while (bus4.BUSYWAIT && b < 40) begin b++; @(negedge CLK); #1; end
        e = sb.pop_front();
        vectors++;
        if (bus4.READDATA !== e) begin errors++; $display("FAIL b2b_first got=%h want=%h", bus4.READDATA, e); end
        addr = 32'h44;
        @(negedge CLK);
        #1;
        vectors++;
        if (bus4.BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b want=1", bus4.BUSYWAIT); end
        b = 0;
        while (bus4.BUSYWAIT && b < 40) begin b++; @(negedge CLK); #1; end
        e = sb.pop_front();
        vectors += 2;
        if (b != 4) begin errors++; $display("FAIL b2b_busy got=%0d want=4", b); end
        if (bus4.READDATA !== e) begin errors++; $display("FAIL b2b_second got=%h want=%h", bus4.READDATA, e); end
        rd = 0;
    endtask

    task automatic test_latency1;
        int b;
        logic [31:0] g, e;
        sel = 1;
        access(0, 1, 32'h8, 32'hCAFEF00D, 3'b010, b, g);
        vectors++;
        if (b != 1) begin errors++; $display("FAIL l1_sw_busy got=%0d want=1", b); end
        sb.push_back(32'hCAFEF00D);
        access(1, 0, 32'h8, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors += 2;
        if (b != 1) begin errors++; $display("FAIL l1_lw_busy got=%0d want=1", b); end
        if (g !== e) begin errors++; $display("FAIL l1_lw_data got=%h want=%h", g, e); end
        sb.push_back(32'hFFFFCAFE);
        access(1, 0, 32'hA, 32'h0, 3'b001, b, g);
        e = sb.pop_front();
        vectors++;
        if (g !== e) begin errors++; $display("FAIL l1_lh_data got=%h want=%h", g, e); end
        sel = 0;
    endtask

    task automatic test_reset_mid;
        int b;
        logic [31:0] g, e;
        access(0, 1, 32'h30, 32'h0, 3'b010, b, g);
        @(negedge CLK);
        wr = 1; addr = 32'h30; wdata = 32'h12345678; f3 = 3'b010;
        @(negedge CLK);
        #1;
        RESET = 0;
        #1;
        vectors++;
        if (bus4.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", bus4.BUSYWAIT); end
        wr = 0;
        repeat (2) @(negedge CLK);
        RESET = 1;
        sb.push_back(32'h0);
        access(1, 0, 32'h30, 32'h0, 3'b010, b, g);
        e = sb.pop_front();
        vectors += 2;
        if (b != 4) begin errors++; $display("FAIL mid_lw_busy got=%0d want=4", b); end
        if (g !== e) begin errors++; $display("FAIL mid_abort got=%h want=%h", g, e); end
    endtask

    task automatic test_random;
        int b;
        logic [31:0] g, e, d, w;
        logic [31:0] m[8];
        logic [1:0] ln;
        logic [2:0] f;
        int k;
        for (int i = 0; i < 8; i++) begin
            m[i] = $urandom;
            access(0, 1, 32'h200 + 4 * i, m[i], 3'b010, b, g);
        end
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 7);
            ln = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                f = 3'($urandom_range(0, 3));
                if (f == 3'b000) m[k][8*ln +: 8] = d[7:0];
                else if (f == 3'b001) m[k][16*ln[1] +: 16] = d[15:0];
                else m[k] = d;
                access(0, 1, 32'h200 + 4 * k + ln, d, f, b, g);
            end else begin
                f = 3'($urandom_range(0, 7));
                w = m[k];
                e = f == 3'b000 ? {{24{w[8*ln+7]}}, w[8*ln +: 8]}
                  : f == 3'b100 ? {24'h0, w[8*ln +: 8]}
                  : f == 3'b001 ? {{16{w[16*ln[1]+15]}}, w[16*ln[1] +: 16]}
                  : f == 3'b101 ? {16'h0, w[16*ln[1] +: 16]}
                  : w;
                sb.push_back(e);
                access(1, 0, 32'h200 + 4 * k + ln, 32'h0, f, b, g);
                e = sb.pop_front();
                vectors++;
                if (g !== e) begin errors++; $display("FAIL rand_load f3=%0d lane=%0d got=%h want=%h", f, ln, g, e); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_extension;
        test_partial_stores;
        test_wrap;
        test_back_to_back;
        test_latency1;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory interface. It services the CPU's MEM_READ/MEM_WRITE requests against an internal word array.
- It holds BUSYWAIT high for a fixed, parameterised number of cycles, which stalls all CPU pipeline registers, then releases BUSYWAIT to complete the access.
- Supports RV32 byte, halfword and word loads and stores, selected by the func3 field carried through the CPU's EX/MEM stage.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two.
- LATENCY, 4, number of cycles BUSYWAIT is high per access; must be >= 1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  load request from the CPU; held stable while BUSYWAIT=1.
- WRITE  input  1  store request from the CPU; held stable while BUSYWAIT=1.
- ADDRESS  input  32  byte address.
- WRITEDATA  input  32  store data; the low byte or halfword is used for SB/SH.
- FUNC3  input  3  access size and sign selection.
- READDATA  output  32  load result, sign- or zero-extended.
- BUSYWAIT  output  1  high while the access is in progress; the CPU stalls.

Behaviour:
- States:
  - IDLE: no access in progress.
  - ACCESS: counting down the access latency.
  - DONE: result available; one cycle only.
- Reset (RESET=0, asynchronous):
  - state = IDLE, counter = 0, READDATA = 0, BUSYWAIT = 0, latched request cleared.
  - Array contents are not cleared.
- BUSYWAIT is combinational. It is 1 when either:
  - state = IDLE and (READ | WRITE) = 1, or
  - state = ACCESS.
  It is 0 in DONE. This asserts BUSYWAIT in the same cycle the request appears, so the CPU does not advance past the request.
- IDLE with a request:
  - Latch op, ADDRESS, WRITEDATA and FUNC3 at the clock edge.
  - If LATENCY = 1: commit at that same edge and go to DONE.
  - Otherwise: load counter = LATENCY-2 and go to ACCESS.
- ACCESS:
  - If counter = 0: commit at this edge and go to DONE.
  - Otherwise: decrement the counter and stay in ACCESS.
- Busy duration: exactly LATENCY cycles of BUSYWAIT=1 per access.
- Commit:
  - A write updates the selected byte lanes of the array.
  - A read registers the aligned, extended word into READDATA.
- DONE:
  - BUSYWAIT = 0 and READDATA is valid. The CPU captures READDATA on the following edge.
  - READ/WRITE are still asserted for the same instruction during this cycle; they are ignored.
  - Next state is always IDLE.
- READDATA holds its value until the next read commit. Writes do not alter READDATA.
- READ and WRITE both high: treated as a write. READDATA is unchanged.
- Addressing:
  - Word index = ADDRESS[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo the array size.
  - Byte lane = ADDRESS[1:0]; halfword lane = ADDRESS[1]. Word accesses ignore ADDRESS[1:0].
  - No misalignment trap is raised.
- FUNC3 decoding:
  - Loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes behave as word accesses.
- Reset mid-access: the access is aborted and the pending write is not performed.
- Back-to-back requests: a new request is recognised only in IDLE, so there is at least one non-busy cycle (DONE) between accesses.

Decomposition:
- Shared package holds:
  - FUNC3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, ACCESS, DONE.
- One combinational sub-module, mem_lane_align:
  - Store path: byte-enable generation and WRITEDATA lane replication.
  - Load path: lane extraction and sign/zero extension.

Test Plan:
- Reset then idle: RESET low then high with READ=WRITE=0 -> BUSYWAIT=0, READDATA=0.
- Store then load, LATENCY=4: SW 0xDEADBEEF to 0x10, then LW from 0x10 -> each access holds BUSYWAIT high for exactly 4 cycles; READDATA=0xDEADBEEF in DONE.
- Byte/half extension: memory word 0x80F17F01; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80F1; LHU @0x10 -> 0x00007F01.
- Partial stores: word 0x11223344; SB 0xAA @offset 1 -> 0x1122AA44; then SH 0xBEEF @offset 2 -> 0xBEEFAA44.
- Latency and wrap: LATENCY=1 -> BUSYWAIT is high for exactly 1 cycle. DEPTH_WORDS=256, SW 0x5 to 0x400 -> LW @0x000 returns 0x5.
- Reset mid-access: SW 0x12345678 to 0x20 over old value 0x0; assert RESET after 2 busy cycles -> BUSYWAIT drops immediately and a subsequent LW @0x20 returns 0x0.
